// File: rtl/microwave_ctrl_pkg.sv
// Shared definitions for the microwave sequencing controller: FSM state
// encodings and the largest accepted BCD keypad digit.
package microwave_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/microwave_ctrl_tick_prescaler.sv
// Free-running divider for the countdown tick: counts 0..TICK_DIV-1 while not
// held and flags the wrap cycle. Reused by the timer bench.
module tick_prescaler #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic clearn,
  input  logic hold,
  input  logic clr,
  output logic wrap
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clearn || clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign wrap = !hold && (cnt == LAST);

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave sequencing controller: keypad entry, cook/pause/done FSM and
// countdown tick gating. Define CTRL_BEEP_EN for a fixed-length done pulse.
module microwave_ctrl
  import microwave_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 50,
  parameter int MAX_DIGITS  = 3,
  parameter int BEEP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_load,
  output logic       timer_enable,
  output logic       timer_clearn,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t        state;
  logic [CW-1:0] digit_cnt;
  logic          key_ok;
  logic          tick_hold;
  logic          tick_clr;
  logic          tick_wrap;

`ifdef CTRL_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] beep_cnt;
`else
  // Latching done needs no pulse length; keep a sanity hook on the parameter.
  if (BEEP_CYCLES < 1) begin : g_beep_cycles_invalid
  end
`endif

  // key_valid is a one-cycle strobe with no back-pressure; digits above 9 drop.
  assign key_ok = key_valid && (key_digit <= BCD_MAX);

  // The tick only advances while actively cooking with nothing overriding it.
  assign tick_hold = !((state == COOK) && door_closed && stopn && !timer_zero);
  assign tick_clr  = !((state == COOK) || (state == PAUSE));

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .clearn (clearn),
    .hold   (tick_hold),
    .clr    (tick_clr),
    .wrap   (tick_wrap)
  );

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!clearn) begin
      state        <= IDLE;
      digit_cnt    <= '0;
      timer_data   <= '0;
      timer_loadn  <= 1'b0;
      timer_load   <= 1'b0;
      timer_enable <= 1'b0;
      timer_clearn <= 1'b0;
      mag_on       <= 1'b0;
      done         <= 1'b0;
`ifdef CTRL_BEEP_EN
      beep_cnt     <= '0;
`endif
    end else begin
      timer_load   <= 1'b0;
      timer_enable <= tick_wrap;
      timer_clearn <= 1'b1;
`ifdef CTRL_BEEP_EN
      beep_cnt     <= (state == DONE) ? beep_cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: begin
          timer_loadn <= 1'b0;
          mag_on      <= 1'b0;
          done        <= 1'b0;
          if (key_ok) begin
            state      <= ENTRY;
            timer_data <= key_digit;
            timer_load <= 1'b1;
            digit_cnt  <= CW'(1);
          end
        end
        ENTRY: begin
          if (!stopn) begin
            state        <= IDLE;
            timer_clearn <= 1'b0;
            digit_cnt    <= '0;
          end else if (!startn && door_closed) begin
            state       <= COOK;
            timer_loadn <= 1'b1;
            mag_on      <= 1'b1;
          end else if (key_ok && (digit_cnt < CW'(MAX_DIGITS))) begin
            timer_data <= key_digit;
            timer_load <= 1'b1;
            digit_cnt  <= digit_cnt + 1'b1;
          end
        end
        COOK: begin
          if (timer_zero) begin
            state  <= DONE;
            mag_on <= 1'b0;
            done   <= 1'b1;
          end else if (!stopn || !door_closed) begin
            state  <= PAUSE;
            mag_on <= 1'b0;
          end else begin
            mag_on <= 1'b1;
          end
        end
        PAUSE: begin
          if (!stopn) begin
            state        <= IDLE;
            timer_clearn <= 1'b0;
            timer_loadn  <= 1'b0;
            digit_cnt    <= '0;
          end else if (!startn && door_closed) begin
            state  <= COOK;
            mag_on <= 1'b1;
          end
        end
        DONE: begin
`ifdef CTRL_BEEP_EN
          if (!stopn || !door_closed || (beep_cnt == BW'(BEEP_CYCLES - 1))) begin
`else
          if (!stopn || !door_closed) begin
`endif
            state       <= IDLE;
            done        <= 1'b0;
            timer_loadn <= 1'b0;
            digit_cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed bench for microwave_ctrl with TICK_DIV=4, MAX_DIGITS=3, BEEP_CYCLES=8.
module tb_microwave_ctrl;
  import microwave_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       clearn;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn;
  logic       timer_load;
  logic       timer_enable;
  logic       timer_clearn;
  logic       mag_on;
  logic       done;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  microwave_ctrl #(.TICK_DIV(4), .MAX_DIGITS(3), .BEEP_CYCLES(8)) dut (
    .clk          (clk),
    .clearn       (clearn),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .startn       (startn),
    .stopn        (stopn),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .timer_data   (timer_data),
    .timer_loadn  (timer_loadn),
    .timer_load   (timer_load),
    .timer_enable (timer_enable),
    .timer_clearn (timer_clearn),
    .mag_on       (mag_on),
    .done         (done),
    .state_o      (state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clearn = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; timer_zero = 1'b0;

    // Reset values
    step();
    check("rst_state", 8'(state_o), 8'(IDLE));
    check("rst_clearn", 8'(timer_clearn), 8'd0);
    check("rst_loadn", 8'(timer_loadn), 8'd0);
    check("rst_load", 8'(timer_load), 8'd0);
    check("rst_enable", 8'(timer_enable), 8'd0);
    check("rst_mag", 8'(mag_on), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_data", 8'(timer_data), 8'd0);
    clearn = 1'b1;
    step();
    check("clearn_release", 8'(timer_clearn), 8'd1);

    // Keys 2,1,7 load; fourth key 9 ignored
    key_valid = 1'b1; key_digit = 4'd2;
    step();
    check("k2_load", 8'(timer_load), 8'd1);
    check("k2_data", 8'(timer_data), 8'd2);
    check("k2_state", 8'(state_o), 8'(ENTRY));
    key_digit = 4'd1;
    step();
    check("k1_load", 8'(timer_load), 8'd1);
    check("k1_data", 8'(timer_data), 8'd1);
    key_digit = 4'd7;
    step();
    check("k7_load", 8'(timer_load), 8'd1);
    check("k7_data", 8'(timer_data), 8'd7);
    key_digit = 4'd9;
    step();
    check("k9_noload", 8'(timer_load), 8'd0);
    check("k9_data", 8'(timer_data), 8'd7);
    check("k9_state", 8'(state_o), 8'(ENTRY));
    key_valid = 1'b0;

    // Start with door open is ignored
    door_closed = 1'b0; startn = 1'b0;
    step();
    check("start_door_open", 8'(state_o), 8'(ENTRY));
    startn = 1'b1; door_closed = 1'b1;
    step();

    // Start, tick every 4th cycle, then timer_zero
    startn = 1'b0;
    step();
    check("cook_state", 8'(state_o), 8'(COOK));
    check("cook_mag", 8'(mag_on), 8'd1);
    check("cook_loadn", 8'(timer_loadn), 8'd1);
    startn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("tick_%0d", k), 8'(timer_enable), ((k % 4) == 0) ? 8'd1 : 8'd0);
      check($sformatf("tick_mag_%0d", k), 8'(mag_on), 8'd1);
    end
    timer_zero = 1'b1;
    step();
    check("done_state", 8'(state_o), 8'(DONE));
    check("done_mag", 8'(mag_on), 8'd0);
    check("done_flag", 8'(done), 8'd1);
    check("done_noenable", 8'(timer_enable), 8'd0);
`ifdef CTRL_BEEP_EN
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("beep_hold_%0d", k), 8'(done), 8'd1);
    end
    step();
    check("beep_end_done", 8'(done), 8'd0);
    check("beep_end_state", 8'(state_o), 8'(IDLE));
`else
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("done_latch_%0d", k), 8'(done), 8'd1);
    end
    stopn = 1'b0;
    step();
    check("done_stop_state", 8'(state_o), 8'(IDLE));
    check("done_stop_done", 8'(done), 8'd0);
    stopn = 1'b1;
`endif
    timer_zero = 1'b0;
    step();

    // Door opened at prescaler=2, resume -> tick 2 cycles later
    key_valid = 1'b1; key_digit = 4'd5;
    step();
    check("k5_state", 8'(state_o), 8'(ENTRY));
    key_valid = 1'b0; startn = 1'b0;
    step();
    check("cook2_state", 8'(state_o), 8'(COOK));
    startn = 1'b1;
    step();
    step();
    door_closed = 1'b0;
    step();
    check("pause_state", 8'(state_o), 8'(PAUSE));
    check("pause_mag", 8'(mag_on), 8'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("pause_noenable_%0d", k), 8'(timer_enable), 8'd0);
      check($sformatf("pause_hold_%0d", k), 8'(state_o), 8'(PAUSE));
    end
    door_closed = 1'b1; startn = 1'b0;
    step();
    check("resume_state", 8'(state_o), 8'(COOK));
    check("resume_mag", 8'(mag_on), 8'd1);
    startn = 1'b1;
    step();
    check("resume_tick1", 8'(timer_enable), 8'd0);
    step();
    check("resume_tick2", 8'(timer_enable), 8'd1);

    // Stop in COOK -> PAUSE; stop+start in PAUSE -> clear pulse, IDLE
    stopn = 1'b0;
    step();
    check("stop_cook_state", 8'(state_o), 8'(PAUSE));
    check("stop_cook_enable", 8'(timer_enable), 8'd0);
    startn = 1'b0;
    step();
    check("stop_pause_state", 8'(state_o), 8'(IDLE));
    check("stop_pause_clearn", 8'(timer_clearn), 8'd0);
    check("stop_pause_loadn", 8'(timer_loadn), 8'd0);
    stopn = 1'b1; startn = 1'b1;
    step();
    check("stop_pause_clearn_end", 8'(timer_clearn), 8'd1);

    // Invalid key in IDLE
    key_valid = 1'b1; key_digit = 4'd12;
    step();
    check("k12_load", 8'(timer_load), 8'd0);
    check("k12_state", 8'(state_o), 8'(IDLE));
    key_valid = 1'b0;

    // Stop in ENTRY
    key_valid = 1'b1; key_digit = 4'd4;
    step();
    key_valid = 1'b0; stopn = 1'b0;
    step();
    check("stop_entry_state", 8'(state_o), 8'(IDLE));
    check("stop_entry_clearn", 8'(timer_clearn), 8'd0);
    stopn = 1'b1;
    step();

    // Enter COOK with timer_zero already set; zero beats door open
    key_valid = 1'b1; key_digit = 4'd1;
    step();
    key_valid = 1'b0; timer_zero = 1'b1; startn = 1'b0;
    step();
    check("zero_entry_cook", 8'(state_o), 8'(COOK));
    startn = 1'b1; door_closed = 1'b0;
    step();
    check("zero_prio_state", 8'(state_o), 8'(DONE));
    check("zero_prio_enable", 8'(timer_enable), 8'd0);
    check("zero_prio_done", 8'(done), 8'd1);
    step();
    check("door_exit_state", 8'(state_o), 8'(IDLE));
    check("door_exit_done", 8'(done), 8'd0);
    door_closed = 1'b1; timer_zero = 1'b0;
    step();

    // Reset mid-cook
    key_valid = 1'b1; key_digit = 4'd3;
    step();
    key_valid = 1'b0; startn = 1'b0;
    step();
    startn = 1'b1;
    step();
    step();
    check("precut_mag", 8'(mag_on), 8'd1);
    clearn = 1'b0;
    step();
    check("cut_state", 8'(state_o), 8'(IDLE));
    check("cut_mag", 8'(mag_on), 8'd0);
    check("cut_loadn", 8'(timer_loadn), 8'd0);
    check("cut_clearn", 8'(timer_clearn), 8'd0);
    check("cut_enable", 8'(timer_enable), 8'd0);
    check("cut_data", 8'(timer_data), 8'd0);
    clearn = 1'b1;
    step();
    check("cut_clearn_end", 8'(timer_clearn), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
